vga_timing_gen: RTL

Parametrised VGA raster timing generator for the display path. It produces horizontal/vertical sync, display-enable, pixel coordinates and frame/line start strobes for any mode described by its porch/sync/active parameters. Sync polarity is programmable and a pixel-clock enable lets it run from the system clock. It feeds the framebuffer read logic and the DAC sync/blank pins.

---
 rtl/vga_timing_gen.sv | 116 +++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: sync, display enable, coordinates and line/frame strobes (frame_cnt under VGA_FRAME_CNT_EN).
// Latency: outputs are registered one clk after the pix_en edge that advances the raster.
// Backpressure: none; pix_en=0 freezes the raster and drops the start strobes.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int CW       = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    output logic          h_sync,
    output logic          v_sync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
`ifdef VGA_FRAME_CNT_EN
    output logic [15:0]   frame_cnt,
`endif
    output logic          sync_n
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic          HP       = H_POL[0];
    localparam logic          VP       = V_POL[0];

    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 || CW == 0) begin : g_zero_param
        $error("vga_timing_gen: timing parameters must be non-zero");
    end
    if (H_TOTAL > 2**CW) begin : g_h_overflow
        $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
    end
    if (V_TOTAL > 2**CW) begin : g_v_overflow
        $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
    end

    logic          h_wrap;
    logic          v_wrap;
    logic [CW-1:0] x_nxt;
    logic [CW-1:0] y_nxt;
    logic          de_nxt;
    logic          hs_act;
    logic          vs_act;

    // Decode from the next counter values so every output lines up with x/y.
    always_comb begin
        h_wrap = (x == H_LAST);
        v_wrap = (y == V_LAST);
        x_nxt  = h_wrap ? '0 : x + CW'(1);
        y_nxt  = y;
        if (h_wrap) begin
            y_nxt = v_wrap ? '0 : y + CW'(1);
        end
        de_nxt = (x_nxt < H_ACT_C) && (y_nxt < V_ACT_C);
        hs_act = (x_nxt >= HS_START) && (x_nxt <= HS_END);
        vs_act = (y_nxt >= VS_START) && (y_nxt <= VS_END);
    end

    // Reset parks the raster on the last back-porch pixel so the first strobe lands on (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            x           <= H_LAST;
            y           <= V_LAST;
            de          <= 1'b0;
            h_sync      <= ~HP;
            v_sync      <= ~VP;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            x           <= x_nxt;
            y           <= y_nxt;
            de          <= de_nxt;
            h_sync      <= hs_act ? HP : ~HP;
            v_sync      <= vs_act ? VP : ~VP;
            line_start  <= h_wrap;
            frame_start <= h_wrap && v_wrap;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= 16'd0;
        end else if (pix_en && h_wrap && v_wrap) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

    assign sync_n = 1'b1;

endmodule
